// File: rtl/usr_pkg.sv
`default_nettype none
// ============================================================================
// Module  : usr_pkg
// Brief   : Shared mode encoding and width helper for the universal shift
//           register and its shift counter.
// Rev     : 1.0 - initial release
// ============================================================================
package usr_pkg;

  // Operation select. Values are fixed by the register's mode encoding.
  typedef enum logic [2:0] {
    USR_HOLD = 3'b000,
    USR_SHL  = 3'b001,
    USR_SHR  = 3'b010,
    USR_ROTL = 3'b011,
    USR_ROTR = 3'b100,
    USR_LOAD = 3'b101,
    USR_CLR  = 3'b110,
    USR_RSVD = 3'b111
  } usr_mode_e;

  // Bits needed to hold a shift count in the range 0..width inclusive.
  function automatic int usr_cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/usr_shift_cnt.sv
`default_nettype none
// ============================================================================
// Module  : usr_shift_cnt
// Brief   : Saturating shift counter with a one-cycle pulse on the edge where
//           the count first reaches WIDTH.
// Rev     : 1.0 - initial release
// ============================================================================
module usr_shift_cnt
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                              c,
  input  logic                              r,
  input  logic                              inc,
  input  logic                              clr,
  output logic [usr_cnt_width(WIDTH)-1:0]   cnt,
  output logic                              done
);

  localparam int                       c_CNT_W   = usr_cnt_width(WIDTH);
  localparam logic [c_CNT_W-1:0]       c_CNT_MAX = c_CNT_W'(WIDTH);
  localparam logic [c_CNT_W-1:0]       c_CNT_PRE = c_CNT_W'(WIDTH - 1);

  logic [c_CNT_W-1:0] r_cnt;
  logic               r_done;

  // Count shifts up to WIDTH; pulse done only on the WIDTH-1 -> WIDTH step.
  // Clear has priority so a load/clear on the saturating edge suppresses done.
  always_ff @(posedge c or negedge r) begin
    if (!r) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (clr) begin
        r_cnt <= '0;
      end else if (inc) begin
        if (r_cnt != c_CNT_MAX) begin
          r_cnt <= r_cnt + 1'b1;
        end
        if (r_cnt == c_CNT_PRE) begin
          r_done <= 1'b1;
        end
      end
    end
  end

  assign cnt  = r_cnt;
  assign done = r_done;

endmodule
`default_nettype wire

// File: rtl/univ_shift_reg.sv
`default_nettype none
// ============================================================================
// Module  : univ_shift_reg
// Brief   : WIDTH-bit universal register: hold, shift left/right, rotate
//           left/right, parallel load and synchronous clear, with a
//           saturating shift counter and done pulse.
// Rev     : 1.0 - initial release
// ============================================================================
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                              c,
  input  logic                              r,
  input  logic                              en,
  input  logic [2:0]                        mode,
  input  logic [WIDTH-1:0]                  d,
  input  logic                              sin_l,
  input  logic                              sin_r,
  output logic [WIDTH-1:0]                  q,
  output logic [WIDTH-1:0]                  qb,
  output logic                              sout_l,
  output logic                              sout_r,
  output logic [usr_cnt_width(WIDTH)-1:0]   cnt,
  output logic                              done
);

  usr_mode_e          w_mode;
  logic [WIDTH-1:0]   w_q_next;
  logic               w_inc;
  logic               w_clr;
  logic [WIDTH-1:0]   r_q;

  assign w_mode = usr_mode_e'(mode);

  // Mode decode: next register value plus counter increment/clear requests.
  // With en low everything holds, which also lets a pending done fall.
  always_comb begin
    w_q_next = r_q;
    w_inc    = 1'b0;
    w_clr    = 1'b0;
    if (en) begin
      case (w_mode)
        USR_SHL: begin
          w_q_next = {r_q[WIDTH-2:0], sin_l};
          w_inc    = 1'b1;
        end
        USR_SHR: begin
          w_q_next = {sin_r, r_q[WIDTH-1:1]};
          w_inc    = 1'b1;
        end
        USR_ROTL: begin
          w_q_next = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
          w_inc    = 1'b1;
        end
        USR_ROTR: begin
          w_q_next = {r_q[0], r_q[WIDTH-1:1]};
          w_inc    = 1'b1;
        end
        USR_LOAD: begin
          w_q_next = d;
          w_clr    = 1'b1;
        end
        USR_CLR: begin
          w_q_next = '0;
          w_clr    = 1'b1;
        end
        default: begin
          w_q_next = r_q;
        end
      endcase
    end
  end

  // Data register with asynchronous active-low reset.
  always_ff @(posedge c or negedge r) begin
    if (!r) begin
      r_q <= '0;
    end else begin
      r_q <= w_q_next;
    end
  end

  usr_shift_cnt #(
    .WIDTH (WIDTH)
  ) u_shift_cnt (
    .c    (c),
    .r    (r),
    .inc  (w_inc),
    .clr  (w_clr),
    .cnt  (cnt),
    .done (done)
  );

  assign q      = r_q;
  assign qb     = ~r_q;
  assign sout_l = r_q[WIDTH-1];
  assign sout_r = r_q[0];

endmodule
`default_nettype wire

// File: tb/tb_univ_shift_reg.sv
`default_nettype none
// ============================================================================
// Module  : tb_univ_shift_reg
// Brief   : Self-checking bench for univ_shift_reg (WIDTH=8): directed vector
//           table, asynchronous reset sequences and randomized operations
//           against an arithmetic reference model.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_univ_shift_reg;

  localparam int WIDTH = 8;
  localparam int CW    = $clog2(WIDTH + 1);

  logic             c;
  logic             r;
  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] d;
  logic             sin_l;
  logic             sin_r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qb;
  logic             sout_l;
  logic             sout_r;
  logic [CW-1:0]    cnt;
  logic             done;

  univ_shift_reg #(.WIDTH(WIDTH)) dut (
    .c      (c),
    .r      (r),
    .en     (en),
    .mode   (mode),
    .d      (d),
    .sin_l  (sin_l),
    .sin_r  (sin_r),
    .q      (q),
    .qb     (qb),
    .sout_l (sout_l),
    .sout_r (sout_r),
    .cnt    (cnt),
    .done   (done)
  );

  initial c = 1'b0;
  always #5 c = ~c;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       en;
    logic [2:0] mode;
    logic [7:0] d;
    logic       sl;
    logic       sr;
    logic [7:0] eq;
    int         ecnt;
    logic       edone;
  } vec_t;

  vec_t tbl[$];

  // Reference model: data as an integer, unbounded shift count since load.
  int m_q;
  int m_shifts;
  bit m_last_shift;

  function automatic vec_t mk(logic e, logic [2:0] m, logic [7:0] dd, logic sl,
                              logic sr, logic [7:0] eq, int ec, logic ed);
    vec_t v;
    v.en = e; v.mode = m; v.d = dd; v.sl = sl; v.sr = sr;
    v.eq = eq; v.ecnt = ec; v.edone = ed;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input int eq, input int ecnt, input int edone);
    chk({tag, " q"},      32'(q),      32'(eq & 8'hFF));
    chk({tag, " qb"},     32'(qb),     32'(~eq & 8'hFF));
    chk({tag, " sout_l"}, 32'(sout_l), 32'((eq >> 7) & 1));
    chk({tag, " sout_r"}, 32'(sout_r), 32'(eq & 1));
    chk({tag, " cnt"},    32'(cnt),    32'(ecnt));
    chk({tag, " done"},   32'(done),   32'(edone));
  endtask

  // Drive one operation and sample just after the rising edge.
  task automatic step(input logic e, input logic [2:0] m, input logic [7:0] dd,
                      input logic sl, input logic sr);
    en = e; mode = m; d = dd; sin_l = sl; sin_r = sr;
    @(posedge c);
    #1;
  endtask

  task automatic model_reset();
    m_q = 0; m_shifts = 0; m_last_shift = 0;
  endtask

  // Apply to DUT and model, then compare.
  task automatic model_step(input string tag, input logic e, input logic [2:0] m,
                            input logic [7:0] dd, input logic sl, input logic sr);
    int ecnt;
    step(e, m, dd, sl, sr);
    m_last_shift = 0;
    if (e) begin
      case (m)
        3'd1: begin m_q = ((m_q * 2) + sl) % 256;                 m_shifts++; m_last_shift = 1; end
        3'd2: begin m_q = (m_q / 2) + (sr ? 128 : 0);              m_shifts++; m_last_shift = 1; end
        3'd3: begin m_q = ((m_q * 2) % 256) + (m_q / 128);         m_shifts++; m_last_shift = 1; end
        3'd4: begin m_q = (m_q / 2) + ((m_q % 2) * 128);           m_shifts++; m_last_shift = 1; end
        3'd5: begin m_q = int'(dd); m_shifts = 0; end
        3'd6: begin m_q = 0;        m_shifts = 0; end
        default: ;
      endcase
    end
    ecnt = (m_shifts > WIDTH) ? WIDTH : m_shifts;
    check_all(tag, m_q, ecnt, (m_last_shift && m_shifts == WIDTH) ? 1 : 0);
  endtask

  initial begin
    // Directed vectors: {en, mode, d, sin_l, sin_r, exp q, exp cnt, exp done}
    tbl.push_back(mk(1, 3'd5, 8'hA5, 0, 0, 8'hA5, 0, 0));
    tbl.push_back(mk(1, 3'd3, 8'h00, 0, 0, 8'h4B, 1, 0));
    tbl.push_back(mk(1, 3'd3, 8'h00, 0, 0, 8'h96, 2, 0));
    tbl.push_back(mk(1, 3'd3, 8'h00, 0, 0, 8'h2D, 3, 0));
    tbl.push_back(mk(1, 3'd3, 8'h00, 0, 0, 8'h5A, 4, 0));
    tbl.push_back(mk(1, 3'd3, 8'h00, 0, 0, 8'hB4, 5, 0));
    tbl.push_back(mk(1, 3'd3, 8'h00, 0, 0, 8'h69, 6, 0));
    tbl.push_back(mk(1, 3'd3, 8'h00, 0, 0, 8'hD2, 7, 0));
    tbl.push_back(mk(1, 3'd3, 8'h00, 0, 0, 8'hA5, 8, 1));
    tbl.push_back(mk(1, 3'd0, 8'h00, 0, 0, 8'hA5, 8, 0));
    tbl.push_back(mk(1, 3'd7, 8'h55, 1, 1, 8'hA5, 8, 0));
    tbl.push_back(mk(1, 3'd3, 8'h00, 0, 0, 8'h4B, 8, 0));
    tbl.push_back(mk(1, 3'd3, 8'h00, 0, 0, 8'h96, 8, 0));
    tbl.push_back(mk(1, 3'd5, 8'h81, 0, 0, 8'h81, 0, 0));
    tbl.push_back(mk(1, 3'd2, 8'h00, 0, 1, 8'hC0, 1, 0));
    tbl.push_back(mk(1, 3'd2, 8'h00, 0, 1, 8'hE0, 2, 0));
    tbl.push_back(mk(1, 3'd2, 8'h00, 0, 1, 8'hF0, 3, 0));
    tbl.push_back(mk(1, 3'd5, 8'h0F, 0, 0, 8'h0F, 0, 0));
    tbl.push_back(mk(1, 3'd1, 8'h00, 0, 0, 8'h1E, 1, 0));
    tbl.push_back(mk(1, 3'd1, 8'h00, 0, 0, 8'h3C, 2, 0));
    tbl.push_back(mk(0, 3'd1, 8'h00, 1, 0, 8'h3C, 2, 0));
    tbl.push_back(mk(0, 3'd5, 8'hFF, 1, 0, 8'h3C, 2, 0));
    tbl.push_back(mk(1, 3'd1, 8'h00, 0, 0, 8'h78, 3, 0));
    tbl.push_back(mk(1, 3'd1, 8'h00, 0, 0, 8'hF0, 4, 0));
    tbl.push_back(mk(1, 3'd1, 8'h00, 0, 0, 8'hE0, 5, 0));
    tbl.push_back(mk(1, 3'd6, 8'hFF, 0, 0, 8'h00, 0, 0));
    tbl.push_back(mk(1, 3'd1, 8'h00, 1, 0, 8'h01, 1, 0));
    tbl.push_back(mk(1, 3'd1, 8'h00, 1, 0, 8'h03, 2, 0));
    tbl.push_back(mk(1, 3'd1, 8'h00, 1, 0, 8'h07, 3, 0));
    tbl.push_back(mk(1, 3'd1, 8'h00, 1, 0, 8'h0F, 4, 0));
    tbl.push_back(mk(1, 3'd1, 8'h00, 1, 0, 8'h1F, 5, 0));
    tbl.push_back(mk(1, 3'd1, 8'h00, 1, 0, 8'h3F, 6, 0));
    tbl.push_back(mk(1, 3'd1, 8'h00, 1, 0, 8'h7F, 7, 0));
    tbl.push_back(mk(1, 3'd5, 8'h3C, 1, 0, 8'h3C, 0, 0));
    tbl.push_back(mk(1, 3'd0, 8'h00, 0, 0, 8'h3C, 0, 0));
    tbl.push_back(mk(1, 3'd6, 8'h00, 0, 0, 8'h00, 0, 0));
    tbl.push_back(mk(1, 3'd5, 8'h01, 0, 0, 8'h01, 0, 0));
    tbl.push_back(mk(1, 3'd4, 8'h00, 0, 0, 8'h80, 1, 0));
    tbl.push_back(mk(1, 3'd4, 8'h00, 0, 0, 8'h40, 2, 0));

    // Asynchronous reset asserted between edges.
    r = 1'b0; en = 1'b0; mode = 3'd0; d = '0; sin_l = 1'b0; sin_r = 1'b0;
    #12;
    check_all("reset", 0, 0, 0);
    r = 1'b1;
    step(1, 3'd0, 8'h00, 0, 0);
    check_all("post-reset hold", 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].en, tbl[i].mode, tbl[i].d, tbl[i].sl, tbl[i].sr);
      check_all($sformatf("vec%0d", i), int'(tbl[i].eq), tbl[i].ecnt, int'(tbl[i].edone));
    end

    // Reset mid-serialization aborts it; counting restarts from zero.
    step(1, 3'd5, 8'hFF, 0, 0);
    step(1, 3'd3, 8'h00, 0, 0);
    step(1, 3'd3, 8'h00, 0, 0);
    step(1, 3'd3, 8'h00, 0, 0);
    #2;
    r = 1'b0;
    #1;
    check_all("mid reset", 0, 0, 0);
    #1;
    r = 1'b1;
    model_reset();
    for (int i = 0; i < 9; i++) begin
      model_step($sformatf("after reset shl%0d", i), 1, 3'd1, 8'h00, 1, 0);
    end

    // Randomized operations against the reference model.
    model_step("rand load", 1, 3'd5, 8'h5A, 0, 0);
    for (int i = 0; i < 400; i++) begin
      logic       e;
      logic [2:0] m;
      e = ($urandom_range(0, 7) != 0);
      // Bias toward shifts so saturation and done are exercised often.
      m = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(1, 4));
      model_step($sformatf("rand%0d", i), e, m, 8'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/univ_shift_reg.md
# univ_shift_reg

Parametrised universal register: a WIDTH-bit register with hold, shift, rotate, parallel load and synchronous clear. It is the generalised successor of the team's single-bit D flip-flop. A saturating shift counter raises a one-cycle `done` pulse after WIDTH shifts since the last load or clear. It sits in serializer/deserializer and bit-stream datapaths wherever a simple DFF stage is too limited.

## Interface
Parameters:
- `WIDTH`, 8, register width in bits; must be ≥ 2.

Ports:
- `c`  in  1  clock; all state changes on the rising edge.
- `r`  in  1  reset, asynchronous, active-low; asserting `r` low clears all state immediately.
- `en`  in  1  operation enable; when 0 the register and counter hold regardless of `mode`.
- `mode`  in  3  operation select (encoding under Operation).
- `d`  in  WIDTH  parallel load data.
- `sin_l`  in  1  serial input, shifted into bit 0 on SHL.
- `sin_r`  in  1  serial input, shifted into bit WIDTH-1 on SHR.
- `q`  out  WIDTH  register contents.
- `qb`  out  WIDTH  bitwise complement of `q`, combinational.
- `sout_l`  out  1  equals `q[WIDTH-1]`, combinational.
- `sout_r`  out  1  equals `q[0]`, combinational.
- `cnt`  out  $clog2(WIDTH+1)  number of shifts/rotates since the last load, clear or reset; saturates at WIDTH.
- `done`  out  1  registered one-cycle pulse when `cnt` reaches WIDTH.

## Operation
Mode encoding, applied only when `en`=1:
- 000 HOLD: `q` unchanged.
- 001 SHL: `q <= {q[WIDTH-2:0], sin_l}`.
- 010 SHR: `q <= {sin_r, q[WIDTH-1:1]}`.
- 011 ROTL: `q <= {q[WIDTH-2:0], q[WIDTH-1]}`.
- 100 ROTR: `q <= {q[0], q[WIDTH-1:1]}`.
- 101 LOAD: `q <= d`.
- 110 CLEAR: `q <= 0`; this is a synchronous clear.
- 111 reserved; behaves exactly as HOLD.

Counter behaviour:
- SHL, SHR, ROTL and ROTR each count as a shift.
- Each shift increments `cnt` by 1. `cnt` saturates at WIDTH and never wraps.
- LOAD and CLEAR set `cnt` to 0.
- HOLD, reserved and `en`=0 leave `cnt` unchanged.

`done` behaviour:
- `done` is 1 in the cycle after the edge on which `cnt` goes from WIDTH-1 to WIDTH; otherwise it is 0.
- A further shift while `cnt`=WIDTH does not re-pulse `done`.

Reset (`r` low, asynchronous):
- `q`=0, `cnt`=0, `done`=0.
- Consequently `qb` = all ones, `sout_l`=0, `sout_r`=0.
- Reset asserted mid-sequence aborts it. After release the block behaves as freshly cleared.

## Timing
- All registered outputs (`q`, `cnt`, `done`) update one cycle after the sampling edge.
- `qb`, `sout_l` and `sout_r` follow `q` combinationally, with zero added latency.
- Serializer use: LOAD, then WIDTH shift cycles. `done` is high in the cycle after the WIDTH-th shift, when `sout_*` has already presented all WIDTH bits.
- LOAD or CLEAR on the same edge that would saturate the counter wins: `cnt`=0 and `done` stays 0.
- When `en` is 0 on a given edge, `done` still falls to 0 on that edge; a pulse is never stretched.
- Reset release: the first rising edge with `r` high performs a normal operation. There are no synchronizer stages inside the block.

## Structure
- Shared package `usr_pkg` holds:
  - the `mode` typedef enum (`USR_HOLD`, `USR_SHL`, `USR_SHR`, `USR_ROTL`, `USR_ROTR`, `USR_LOAD`, `USR_CLR`, `USR_RSVD`);
  - the function computing the `cnt` width.
- One sub-module, `usr_shift_cnt`, holds the saturating counter and `done` pulse logic. Its inputs are `c`, `r`, an increment signal and a clear signal.
- The top level contains the data register and the mode decode.

## Test plan
- Reset: drive `r`=0 asynchronously between edges. Expect `q`=8'h00, `qb`=8'hFF, `cnt`=0 and `done`=0 immediately. After release with HOLD, `q` stays 0.
- LOAD 8'hA5, then ROTL ×8. Expect `q` sequence A5, 4B, 96, 2D, 5A, B4, 69, D2, A5. `done`=1 exactly once, in the cycle after the 8th rotate. `cnt`=8.
- LOAD 8'h81, then SHR ×3 with `sin_r`=1. Expect `q`=C0, E0, F0. `sout_r` shows 1, 0, 0, 0 over those cycles.
- Load 8'h0F and perform 5 SHL with `sin_l`=0, holding `en`=0 for 2 cycles partway through. During those 2 cycles `q` and `cnt` freeze. Final `q`=8'hE0 and `cnt`=5.
- Perform 7 shifts, then on the 8th edge apply LOAD 8'h3C. Expect `cnt`=0, `done` never asserted, `q`=3C. Then CLEAR: `q`=00.
- Reserved mode 111 with `en`=1: `q` and `cnt` unchanged. Saturation: after 10 shifts `cnt` stays 8 and `done` pulsed only once.
